// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: tracks in-flight destination registers,
// selects forwarding sources and stalls on load-use hazards.
module pipe_hazard_ctrl #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned RAW        = 5,
  parameter int unsigned LOAD_STAGE = 2,
  localparam int unsigned FW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RAW-1:0]   id_rs,
  input  logic [RAW-1:0]   id_rt,
  input  logic [RAW-1:0]   id_rwd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [FW-1:0]    rs_fwd,
  output logic [FW-1:0]    rt_fwd,
  output logic [DEPTH-1:0] stage_valid,
  output logic [31:0]      stall_cnt
);

  typedef struct packed {
    logic           valid;
    logic           we;
    logic           is_load;
    logic [RAW-1:0] rwd;
  } stage_t;

  stage_t        stage_q [DEPTH];
  logic          rs_hit, rt_hit;
  logic          rs_load, rt_load;
  logic [FW-1:0] rs_sel, rt_sel;

  // Lowest matching stage index wins; register 0 never matches.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_load = 1'b0;
    rt_load = 1'b0;
    rs_sel  = '0;
    rt_sel  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!rs_hit && stage_q[k].valid && stage_q[k].we &&
          stage_q[k].rwd == id_rs && id_rs != '0) begin
        rs_hit  = 1'b1;
        rs_sel  = FW'(k + 1);
        rs_load = stage_q[k].is_load && (k < LOAD_STAGE);
      end
      if (!rt_hit && stage_q[k].valid && stage_q[k].we &&
          stage_q[k].rwd == id_rt && id_rt != '0) begin
        rt_hit  = 1'b1;
        rt_sel  = FW'(k + 1);
        rt_load = stage_q[k].is_load && (k < LOAD_STAGE);
      end
    end
  end

  assign rs_fwd = id_valid ? rs_sel : '0;
  assign rt_fwd = id_valid ? rt_sel : '0;
  assign stall  = id_valid && !flush && (rs_load || rt_load);

  always_comb begin
    stage_valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      stage_valid[k] = stage_q[k].valid;
    end
  end

  // Stages always advance; a stall or flush injects a bubble into stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      if (stall || flush) begin
        stage_q[0] <= '0;
      end else begin
        stage_q[0] <= {id_valid, id_we, id_is_load, id_rwd};
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
      if (stall && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a DEPTH=5/LOAD_STAGE=3 instance.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;

  logic        id_valid, id_we, id_is_load, flush;
  logic [4:0]  id_rs, id_rt, id_rwd;
  logic        stall;
  logic [1:0]  rs_fwd, rt_fwd;
  logic [2:0]  stage_valid;
  logic [31:0] stall_cnt;

  logic        p_valid, p_we, p_is_load, p_flush;
  logic [4:0]  p_rs, p_rt, p_rwd;
  logic        p_stall;
  logic [2:0]  p_rs_fwd, p_rt_fwd;
  logic [4:0]  p_stage_valid;
  logic [31:0] p_stall_cnt;

  int n_cmp;
  int n_err;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rwd(id_rwd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.DEPTH(5), .RAW(5), .LOAD_STAGE(3)) dut_p (
    .clk(clk), .rst(rst), .id_valid(p_valid), .id_rs(p_rs), .id_rt(p_rt),
    .id_rwd(p_rwd), .id_we(p_we), .id_is_load(p_is_load), .flush(p_flush),
    .stall(p_stall), .rs_fwd(p_rs_fwd), .rt_fwd(p_rt_fwd),
    .stage_valid(p_stage_valid), .stall_cnt(p_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rwd, input logic we, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_rwd = rwd; id_we = we; id_is_load = ld;
    #1;
  endtask

  task automatic p_issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rwd, input logic we, input logic ld);
    p_valid = v; p_rs = rs; p_rt = rt; p_rwd = rwd; p_we = we; p_is_load = ld;
    #1;
  endtask

  task automatic drain();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    flush = 1'b0;
    p_flush = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    p_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rs_fwd", 32'(rs_fwd), 32'd0);
    chk("rst_rt_fwd", 32'(rt_fwd), 32'd0);
    chk("rst_stage_valid", 32'(stage_valid), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);

    // ALU chain: add r3 then consumers of r3
    issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    chk("alu_first_fwd", 32'(rs_fwd), 32'd0);
    tick();
    issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("alu_fwd1", 32'(rs_fwd), 32'd1);
    chk("alu_stall1", 32'(stall), 32'd0);
    tick();
    chk("alu_fwd2", 32'(rs_fwd), 32'd2);
    tick();
    chk("alu_fwd3", 32'(rs_fwd), 32'd3);
    chk("alu_valid", 32'(stage_valid), 32'b111);
    tick();
    chk("alu_fwd0", 32'(rs_fwd), 32'd0);
    drain();
    chk("drain_valid", 32'(stage_valid), 32'd0);

    // Load-use: load r5, then user of rt=5
    issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0);
    chk("lu_stall_a", 32'(stall), 32'd1);
    chk("lu_rt_fwd_a", 32'(rt_fwd), 32'd1);
    tick();
    chk("lu_stall_b", 32'(stall), 32'd1);
    chk("lu_rt_fwd_b", 32'(rt_fwd), 32'd2);
    chk("lu_valid_b", 32'(stage_valid), 32'b010);
    chk("lu_cnt_b", stall_cnt, 32'd1);
    tick();
    chk("lu_stall_c", 32'(stall), 32'd0);
    chk("lu_rt_fwd_c", 32'(rt_fwd), 32'd3);
    chk("lu_valid_c", 32'(stage_valid), 32'b100);
    chk("lu_cnt_c", stall_cnt, 32'd2);
    tick();
    chk("lu_valid_d", 32'(stage_valid), 32'b001);
    chk("lu_cnt_d", stall_cnt, 32'd2);
    drain();

    // Youngest producer wins: r7 in stage 2 and stage 0, r8 in stage 1
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    chk("yw_rs_fwd", 32'(rs_fwd), 32'd1);
    chk("yw_rt_fwd", 32'(rt_fwd), 32'd1);
    issue(1'b1, 5'd8, 5'd7, 5'd0, 1'b0, 1'b0);
    chk("yw_rs_fwd_r8", 32'(rs_fwd), 32'd2);
    issue(1'b0, 5'd8, 5'd7, 5'd0, 1'b0, 1'b0);
    chk("yw_invalid_rs", 32'(rs_fwd), 32'd0);
    chk("yw_invalid_rt", 32'(rt_fwd), 32'd0);
    drain();

    // Register 0 never forwards
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    chk("r0_rs_fwd", 32'(rs_fwd), 32'd0);
    chk("r0_rt_fwd", 32'(rt_fwd), 32'd0);
    drain();

    // Flush during a load-use hazard
    issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd9, 5'd0, 5'd2, 1'b1, 1'b0);
    chk("fl_pre_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("fl_valid", 32'(stage_valid), 32'b010);
    chk("fl_cnt", stall_cnt, 32'd2);
    drain();

    // Reset pulsed mid-stall
    issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    tick();
    issue(1'b1, 5'd4, 5'd0, 5'd10, 1'b1, 1'b0);
    chk("rs_pre_stall", 32'(stall), 32'd1);
    tick();
    chk("rs_mid_stall", 32'(stall), 32'd1);
    chk("rs_mid_cnt", stall_cnt, 32'd3);
    rst = 1'b1;
    tick();
    chk("rs_stall", 32'(stall), 32'd0);
    chk("rs_valid", 32'(stage_valid), 32'd0);
    chk("rs_cnt", stall_cnt, 32'd0);
    rst = 1'b0;
    tick();
    chk("rs_enter_valid", 32'(stage_valid), 32'b001);
    chk("rs_enter_stall", 32'(stall), 32'd0);
    drain();

    // DEPTH=5, LOAD_STAGE=3: three stall cycles, then forward from stage 3
    p_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    tick();
    p_issue(1'b1, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0);
    chk("p_stall_a", 32'(p_stall), 32'd1);
    chk("p_fwd_a", 32'(p_rt_fwd), 32'd1);
    tick();
    chk("p_stall_b", 32'(p_stall), 32'd1);
    chk("p_fwd_b", 32'(p_rt_fwd), 32'd2);
    tick();
    chk("p_stall_c", 32'(p_stall), 32'd1);
    chk("p_fwd_c", 32'(p_rt_fwd), 32'd3);
    tick();
    chk("p_stall_d", 32'(p_stall), 32'd0);
    chk("p_fwd_d", 32'(p_rt_fwd), 32'd4);
    chk("p_cnt_d", p_stall_cnt, 32'd3);
    chk("p_valid_d", 32'(p_stage_valid), 32'b01000);
    p_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (5) tick();

    // Counter saturation from a preset near the top
    force dut_p.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut_p.stall_cnt;
    #1;
    chk("sat_preset", p_stall_cnt, 32'hFFFF_FFFE);
    p_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    tick();
    p_issue(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    tick();
    chk("sat_cnt_1", p_stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_cnt_2", p_stall_cnt, 32'hFFFF_FFFF);
    chk("sat_still_stall", 32'(p_stall), 32'd1);
    tick();
    chk("sat_cnt_3", p_stall_cnt, 32'hFFFF_FFFF);
    chk("sat_stall_done", 32'(p_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
